// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-wide SPI mode-0 master with debounced card detect and abort on card removal
module sd_spi_master #(
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int CNT_WIDTH = 16
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic [7:0] div,
  input  logic       cs_req,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic       card_present,
  output logic       sd_cs_n,
  output logic       sd_sck,
  output logic       sd_mosi,
  input  logic       sd_miso,
  input  logic       sd_cd
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t state;
  logic cd_s1, cd_s2;
  logic [CNT_WIDTH-1:0] cnt;
  logic [7:0] hc, dl, tx, rx;
  logic [2:0] bc;
  // sd_cd is active low; count only while the synchronised level disagrees with card_present
  always_ff @(posedge clk_core) begin
    if (reset) begin
      cd_s1 <= 1'b1;
      cd_s2 <= 1'b1;
      cnt <= '0;
      card_present <= 1'b0;
    end else begin
      cd_s1 <= sd_cd;
      cd_s2 <= cd_s1;
      if (~cd_s2 == card_present) cnt <= '0;
      else if (cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        card_present <= ~card_present;
      end else cnt <= cnt + 1'b1;
    end
  end
  always_ff @(posedge clk_core) begin
    if (reset) begin
      state <= IDLE;
      sd_cs_n <= 1'b1;
      sd_sck <= 1'b0;
      sd_mosi <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_data <= 8'hFF;
      busy <= 1'b0;
      cmd_ready <= 1'b0;
      hc <= '0;
      dl <= '0;
      tx <= '0;
      rx <= '0;
      bc <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          sd_cs_n <= ~(cs_req & card_present);
          if (!card_present) sd_mosi <= 1'b1;
          if (cmd_valid && cmd_ready && card_present) begin
            tx <= cmd_data;
            sd_mosi <= cmd_data[7];
            dl <= div;
            hc <= div;
            bc <= '0;
            busy <= 1'b1;
            cmd_ready <= 1'b0;
            state <= LOW;
          end else if (cmd_valid && cmd_ready) begin
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_data <= 8'hFF;
          end
        end
        LOW, HIGH: begin
          if (!card_present) begin
            sd_sck <= 1'b0;
            sd_cs_n <= 1'b1;
            sd_mosi <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_data <= 8'hFF;
            busy <= 1'b0;
            cmd_ready <= 1'b1;
            state <= IDLE;
          end else if (hc != 8'd0) hc <= hc - 8'd1;
          else if (state == LOW) begin
            sd_sck <= 1'b1;
            rx <= {rx[6:0], sd_miso};
            hc <= dl;
            state <= HIGH;
          end else begin
            sd_sck <= 1'b0;
            hc <= dl;
            if (bc == 3'd7) state <= DONE;
            else begin
              bc <= bc + 3'd1;
              tx <= {tx[6:0], 1'b0};
              sd_mosi <= tx[6];
              state <= LOW;
            end
          end
        end
        DONE: begin
          rsp_valid <= 1'b1;
          rsp_data <= rx;
          rsp_err <= 1'b0;
          busy <= 1'b0;
          sd_mosi <= 1'b1;
          cmd_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: randomized scoreboard bench for sd_spi_master
module tb_sd_spi_master;
  logic clk_core = 1'b0;
  logic reset = 1'b1;
  logic [7:0] div = 8'd0, cmd_data = 8'd0;
  logic cs_req = 1'b0, cmd_valid = 1'b0, sd_cd = 1'b0, sd_miso;
  logic cmd_ready, rsp_valid, rsp_err, busy, card_present, sd_cs_n, sd_sck, sd_mosi;
  logic [7:0] rsp_data;
  int compared = 0, mismatched = 0;
  logic [8:0] sb[$];
  logic [8:0] exp_rsp;
  int miso_mode = 0;
  logic [7:0] pat = 8'd0;
  int rise_cnt = 0, rise_base = 0, hi_total = 0, cs_hi_total = 0;
  logic [7:0] mosi_sh = 8'd0;

  sd_spi_master #(.DEBOUNCE_CYCLES(8), .CNT_WIDTH(4)) dut (
    .clk_core(clk_core), .reset(reset), .div(div), .cs_req(cs_req),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .card_present(card_present), .sd_cs_n(sd_cs_n), .sd_sck(sd_sck),
    .sd_mosi(sd_mosi), .sd_miso(sd_miso), .sd_cd(sd_cd)
  );

  always #5 clk_core = ~clk_core;

  // card model: loopback, constant 1, or a pattern byte presented MSB first per SCK rise
  assign sd_miso = (miso_mode == 0) ? sd_mosi : (miso_mode == 1) ? 1'b1 : pat[7 - ((rise_cnt - rise_base) & 7)];

  always @(posedge sd_sck) begin
    rise_cnt <= rise_cnt + 1;
    mosi_sh <= {mosi_sh[6:0], sd_mosi};
  end

  always @(negedge clk_core) begin
    if (sd_sck) hi_total++;
    if (sd_cs_n) cs_hi_total++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk_core) begin
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rsp_unexpected: got %0h, expected no response", {rsp_err, rsp_data});
      end else begin
        exp_rsp = sb.pop_front();
        check("rsp", {23'd0, rsp_err, rsp_data}, {23'd0, exp_rsp});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk_core); #1;
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 3000) begin
      @(posedge clk_core); #1;
      n++;
    end
  endtask

  task automatic xfer(input logic [7:0] b, input int dexp, input logic [7:0] exp_data, output int cs_hi);
    int n, hi0, cs0;
    wait_ready();
    cmd_data = b;
    cmd_valid = 1'b1;
    sb.push_back({1'b0, exp_data});
    rise_base = rise_cnt;
    hi0 = hi_total;
    cs0 = cs_hi_total;
    @(posedge clk_core); #1;
    cmd_valid = 1'b0;
    wait_rsp(n);
    check("latency", n, 16 * (dexp + 1) + 1);
    check("sck_high_cycles", hi_total - hi0, 8 * (dexp + 1));
    check("mosi_bits", {24'd0, mosi_sh}, {24'd0, b});
    cs_hi = cs_hi_total - cs0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cs_hi, n, r0;
    logic [7:0] b, e;
    repeat (3) @(posedge clk_core);
    #1;
    check("reset_outputs", {sd_cs_n, sd_sck, sd_mosi, rsp_valid, rsp_err, busy, card_present, cmd_ready},
          8'b1010_0000);
    check("reset_rsp_data", rsp_data, 8'hFF);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_core); #1;
      if (k == 1) check("cmd_ready_after_reset", cmd_ready, 1);
      if (k == 9) check("card_present_early", card_present, 0);
      if (k == 10) check("card_present_rise", card_present, 1);
    end
    @(posedge clk_core); #1;
    check("cs_idle_no_req", sd_cs_n, 1);
    cs_req = 1'b1;
    @(posedge clk_core); #1;
    check("cs_asserted", sd_cs_n, 0);

    miso_mode = 0;
    div = 8'd0;
    xfer(8'hA5, 0, 8'hA5, cs_hi);
    check("cs_low_a5", cs_hi, 0);

    miso_mode = 1;
    div = 8'd3;
    xfer(8'h00, 3, 8'hFF, cs_hi);

    fork
      xfer(8'h3C, 3, 8'hFF, cs_hi);
      begin
        repeat (12) @(posedge clk_core);
        #2;
        div = 8'd0;
        cs_req = 1'b0;
      end
    join
    check("cs_held_mid", cs_hi, 0);
    check("cs_held_done", sd_cs_n, 0);
    @(posedge clk_core); #1;
    check("cs_release_idle", sd_cs_n, 1);

    cs_req = 1'b1;
    miso_mode = 0;
    @(posedge clk_core); #1;
    wait_ready();
    r0 = cs_hi_total;
    cmd_data = 8'h40;
    cmd_valid = 1'b1;
    sb.push_back({1'b0, 8'h40});
    sb.push_back({1'b0, 8'h95});
    @(posedge clk_core); #1;
    wait_rsp(n);
    check("b2b_lat1", n, 17);
    cmd_data = 8'h95;
    @(posedge clk_core); #1;
    cmd_valid = 1'b0;
    check("b2b_accept", {busy, cmd_ready}, 2'b10);
    wait_rsp(n);
    check("b2b_lat2", n, 17);
    check("b2b_mosi", {24'd0, mosi_sh}, 32'h95);
    check("b2b_cs_low", cs_hi_total - r0, 0);

    for (int i = 0; i < 6; i++) begin
      div = 8'($urandom_range(0, 3));
      miso_mode = $urandom_range(0, 2);
      pat = 8'($urandom);
      b = 8'($urandom);
      e = (miso_mode == 0) ? b : (miso_mode == 1) ? 8'hFF : pat;
      xfer(b, int'(div), e, cs_hi);
      check("rand_cs_low", cs_hi, 0);
    end

    div = 8'd3;
    miso_mode = 2;
    pat = 8'($urandom);
    wait_ready();
    sb.push_back({1'b1, 8'hFF});
    rise_base = rise_cnt;
    cmd_data = 8'($urandom);
    cmd_valid = 1'b1;
    @(posedge clk_core); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (rise_cnt - rise_base < 5 && n < 200) begin
      @(posedge clk_core); #1;
      n++;
    end
    check("abort_reach_bit4", rise_cnt - rise_base, 5);
    @(negedge clk_core);
    sd_cd = 1'b1;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk_core); #1;
      n++;
    end
    check("abort_latency", n, 11);
    check("abort_pins", {sd_sck, sd_cs_n, sd_mosi, busy, card_present, cmd_ready}, 6'b011001);
    check("abort_rsp", {rsp_err, rsp_data}, 9'h1FF);

    @(posedge clk_core); #1;
    r0 = rise_cnt;
    wait_ready();
    sb.push_back({1'b1, 8'hFF});
    cmd_data = 8'h5A;
    cmd_valid = 1'b1;
    @(posedge clk_core); #1;
    cmd_valid = 1'b0;
    check("drop_rsp_next", rsp_valid, 1);
    repeat (5) @(posedge clk_core);
    #1;
    check("drop_no_sck", rise_cnt - r0, 0);
    check("drop_not_busy", {busy, sd_cs_n}, 2'b01);
    repeat (2) @(posedge clk_core);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
